// File: rtl/fetch_pc_unit.sv
// Fetch-stage program counter: next-PC selection, CP0 redirects, stall hold,
// fetch address exception detection and a count of sequential fetch advances.
module fetch_pc_unit #(
   parameter logic [31:0] RESET_PC   = 32'h0000_3000,
   parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
   parameter logic [31:0] IM_LO      = 32'h0000_3000,
   parameter logic [31:0] IM_HI      = 32'h0000_6FFC
) (
   input  logic        CLK,
   input  logic        reset,
   input  logic        FREEZE,
   input  logic [1:0]  NPC_sel,
   input  logic        branch_taken,
   input  logic [31:0] id_PCp4,
   input  logic [15:0] imm16,
   input  logic [25:0] instr_index,
   input  logic [31:0] jr_target,
   input  logic        exc_req,
   input  logic        eret_req,
   input  logic [31:0] epc,
   output logic [31:0] PC,
   output logic [31:0] PCp4,
   output logic [4:0]  X_out,
   output logic        flush,
   output logic [31:0] fetch_cnt
);

   localparam int unsigned XLEN    = 32;
   localparam int unsigned EXC_W   = 5;
   localparam int unsigned IMM_W   = 16;
   localparam int unsigned SEXT_W  = XLEN - IMM_W - 2;

   localparam logic [EXC_W-1:0] EXC_NONE = EXC_W'(0);
   localparam logic [EXC_W-1:0] EXC_ADEL = EXC_W'(4);

   localparam logic [1:0] SEL_SEQ    = 2'b00;
   localparam logic [1:0] SEL_BRANCH = 2'b01;
   localparam logic [1:0] SEL_JUMP   = 2'b10;
   localparam logic [1:0] SEL_JR     = 2'b11;

   logic [XLEN-1:0] branch_off;
   logic [XLEN-1:0] branch_tgt;
   logic [XLEN-1:0] jump_tgt;
   logic [XLEN-1:0] npc;
   logic            redirect;
   logic            pc_misaligned;
   logic            pc_out_of_range;

   // Sequential fetch address, wraps modulo 2^32.
   assign PCp4 = PC + XLEN'(4);

   // Branch and jump targets relative to the instruction in decode.
   assign branch_off = {{SEXT_W{imm16[IMM_W-1]}}, imm16, 2'b00};
   assign branch_tgt = id_PCp4 + branch_off;
   assign jump_tgt   = {id_PCp4[31:28], instr_index, 2'b00};

   // Either CP0 request forces a redirect; exception wins over eret.
   assign redirect = exc_req | eret_req;

   // Next-PC select for a normal (non-redirect, non-stalled) advance.
   always_comb begin
      npc = PCp4;
      case (NPC_sel)
         SEL_SEQ:    npc = PCp4;
         SEL_BRANCH: npc = branch_taken ? branch_tgt : PCp4;
         SEL_JUMP:   npc = jump_tgt;
         SEL_JR:     npc = jr_target;
         default:    npc = PCp4;
      endcase
   end

   // Fetch address error: misaligned or outside the instruction memory window.
   always_comb begin
      pc_misaligned   = (PC[1:0] != 2'b00);
      pc_out_of_range = (PC < IM_LO) || (PC > IM_HI);
      X_out           = EXC_NONE;
      if (pc_misaligned || pc_out_of_range) begin
         X_out = EXC_ADEL;
      end
   end

   // PC, flush pulse and fetch counter; redirects override a stall.
   always_ff @(posedge CLK) begin
      if (reset) begin
         PC        <= RESET_PC;
         flush     <= 1'b0;
         fetch_cnt <= '0;
      end else begin
         flush <= redirect;
         if (exc_req) begin
            PC <= HANDLER_PC;
         end else if (eret_req) begin
            PC <= epc;
         end else if (!FREEZE) begin
            PC        <= npc;
            fetch_cnt <= fetch_cnt + XLEN'(1);
         end
      end
   end

endmodule

// File: doc/fetch_pc_unit.md
FETCH_PC_UNIT -- requirements
Module: fetch_pc_unit

Interface
REQ-001 SHALL have the following ports (name, direction, width, meaning):
- CLK  in  1  clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- FREEZE  in  1  pipeline stall; holds the fetch PC.
- NPC_sel  in  2  next-PC select: 00 sequential, 01 conditional branch, 10 j/jal, 11 jr/jalr.
- branch_taken  in  1  branch condition from decode; used only when NPC_sel=01.
- id_PCp4  in  32  PC+4 of the instruction in decode.
- imm16  in  16  branch offset field of the instruction in decode.
- instr_index  in  26  jump index field of the instruction in decode.
- jr_target  in  32  forwarded register target for jr/jalr.
- exc_req  in  1  exception commit request from CP0.
- eret_req  in  1  eret commit request.
- epc  in  32  return address for eret.
- PC  out  32  current fetch address.
- PCp4  out  32  PC+4, feeds the IF/ID register.
- X_out  out  5  fetch exception code, feeds the IF/ID register.
- flush  out  1  one-cycle pulse that clears downstream pipeline registers.
- fetch_cnt  out  32  count of fetch advances.
REQ-002 SHALL use reset as a synchronous, active-high reset and CLK as the clock.
REQ-003 SHALL have the following parameters (name, default, meaning):
- RESET_PC  32'h0000_3000  boot address.
- HANDLER_PC  32'h0000_4180  exception entry address.
- IM_LO  32'h0000_3000  lowest valid instruction address.
- IM_HI  32'h0000_6FFC  highest valid instruction address.

Function
REQ-004 SHALL hold PC in a 32-bit register; PCp4 SHALL equal PC+4 combinationally, with 32-bit wrap and no carry-out.
REQ-005 SHALL compute branch_tgt as id_PCp4 + ({{14{imm16[15]}}, imm16, 2'b00}), modulo 2^32.
REQ-006 SHALL compute jump_tgt as {id_PCp4[31:28], instr_index, 2'b00}.
REQ-007 SHALL select npc as follows:
- NPC_sel=00: PCp4.
- NPC_sel=01: branch_tgt when branch_taken=1, otherwise PCp4.
- NPC_sel=10: jump_tgt.
- NPC_sel=11: jr_target.
REQ-008 SHALL resolve PC update priority per edge, highest first:
- reset: PC <= RESET_PC.
- exc_req: PC <= HANDLER_PC.
- eret_req: PC <= epc.
- FREEZE: PC held.
- otherwise: PC <= npc.
REQ-009 SHALL let exc_req and eret_req override FREEZE; a redirect SHALL never be lost to a stall.
REQ-010 SHALL take exc_req and ignore eret_req when both are asserted in the same cycle.
REQ-011 SHALL drive X_out = 5'd4 (AdEL) when PC[1:0]!=0, PC<IM_LO, or PC>IM_HI; otherwise X_out = 5'd0; the comparisons SHALL be unsigned.
REQ-012 SHALL load jr_target unmodified even when it is misaligned; the fault SHALL be reported only through X_out on the following cycle.
REQ-013 SHALL register flush: flush <= 1 on an edge where exc_req or eret_req is taken, otherwise 0; flush SHALL be high exactly one cycle per redirect.
REQ-014 SHALL set flush for each of two back-to-back redirect requests, giving a two-cycle high with PC following the latest request.
REQ-015 SHALL increment fetch_cnt by 1 on every edge where PC <= npc is taken (not reset, not redirect, not frozen); fetch_cnt SHALL wrap from 32'hFFFF_FFFF to 0.
REQ-016 SHALL not count redirect edges in fetch_cnt.
REQ-017 SHALL update no state in any cycle where FREEZE=1 and no redirect is requested.
REQ-018 SHALL have zero-cycle latency from PC to the PCp4 and X_out outputs, and one-cycle latency from npc, redirect or reset to PC.

Reset
REQ-019 SHALL on reset set PC=RESET_PC, flush=0 and fetch_cnt=0, regardless of FREEZE, exc_req or eret_req.
REQ-020 SHALL present PCp4=32'h0000_3004 and X_out=0 in the cycle after reset.
REQ-021 SHALL honour reset asserted mid-stall or mid-redirect on the next edge; no pending redirect SHALL survive reset.

Verification
REQ-022 Reset, then 3 cycles with NPC_sel=00 -> PC sequence 3000, 3004, 3008, 300C; fetch_cnt=3; X_out=0 throughout.
REQ-023 FREEZE=1 for 2 cycles at PC=3008 with NPC_sel=10 -> PC holds 3008 and fetch_cnt is unchanged; after release, PC=jump_tgt.
REQ-024 NPC_sel=01, branch_taken=1, id_PCp4=3010, imm16=FFFE -> next PC=3008; with branch_taken=0 -> next PC=PCp4.
REQ-025 exc_req=1 together with FREEZE=1 -> next PC=4180 and flush=1 for one cycle; exc_req and eret_req together -> PC=4180.
REQ-026 NPC_sel=11, jr_target=3002 -> PC=3002 and X_out=4; jr_target=7000 -> X_out=4; eret_req with epc=3020 -> PC=3020, flush pulse, X_out=0.
REQ-027 reset asserted during FREEZE with exc_req=1 -> PC=3000, flush=0, fetch_cnt=0 on the next edge.
